lfsr_checker: RTL and testbench

Receive-side companion to the LFSR generator top. It consumes the 32-bit words that the generator emits on its result bus, each word qualified by a valid strobe. It self-synchronises by seeding from the first non-zero word, then predicts every following word and flags mismatches. It counts errors and declares loss of lock after a run of consecutive errors, so the generator can be checked on silicon or in system simulation.

---
 rtl/lfsr_checker_pkg.sv | 19 +
 rtl/lfsr_checker_step.sv | 19 +
 rtl/lfsr_checker.sv | 100 ++++++++++
 tb/tb_lfsr_checker.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared LFSR definitions: one polynomial for the generator and the checker,
// the checker lock states, and the single-step function.
package lfsr_checker_pkg;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Fibonacci step: shift left, parity of tapped bits into the LSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x,
                                                  input logic [LFSR_W-1:0] taps);
    return {x[LFSR_W-2:0], ^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr_checker_step.sv
// Combinational one-step LFSR advance.
module lfsr_step
  import lfsr_checker_pkg::*;
#(
  parameter int               WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  // Non-default widths cannot go through the fixed-width package function.
  if (WIDTH == LFSR_W) begin : g_pkg
    assign nxt = lfsr_next(cur, TAPS);
  end else begin : g_gen
    assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: seeds from the first non-zero word, then predicts
// each following word, counts mismatches and drops lock on a run of errors.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int               WIDTH       = LFSR_W,
  parameter logic [WIDTH-1:0] TAPS        = LFSR_TAPS,
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             match,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       THRESH  = 8'(LOSS_THRESH);

  lock_state_e      state, state_d;
  logic [7:0]       consec, consec_d, consec_inc;
  logic [CNT_W-1:0] err_d;
  logic [WIDTH-1:0] exp_d, step_in, step_out;
  logic             match_d, mism_d;

  // One stepper serves both seeding (from the received word) and prediction.
  assign step_in = (state == LOCKED) ? expected : in_data;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .cur (step_in),
    .nxt (step_out)
  );

  assign consec_inc = consec + 8'd1;
  assign locked     = (state == LOCKED);

  always_comb begin
    state_d  = state;
    exp_d    = expected;
    consec_d = consec;
    err_d    = err_count;
    match_d  = 1'b0;
    mism_d   = 1'b0;
    if (in_valid) begin
      unique case (state)
        UNLOCKED: begin
          // Zero is the LFSR lock-up value and can never seed.
          if (in_data != '0) begin
            exp_d    = step_out;
            consec_d = 8'd0;
            state_d  = LOCKED;
          end
        end
        LOCKED: begin
          exp_d = step_out;
          if (in_data == expected) begin
            match_d  = 1'b1;
            consec_d = 8'd0;
          end else begin
            mism_d = 1'b1;
            if (err_count != CNT_MAX) err_d = err_count + 1'b1;
            if (consec_inc == THRESH) begin
              state_d  = UNLOCKED;
              consec_d = 8'd0;
            end else begin
              consec_d = consec_inc;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
    if (clear_cnt) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOCKED;
      expected  <= '0;
      consec    <= 8'd0;
      err_count <= '0;
      match     <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      state     <= state_d;
      expected  <= exp_d;
      consec    <= consec_d;
      err_count <= err_d;
      match     <= match_d;
      mismatch  <= mism_d;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a narrow-counter,
// high-threshold instance for saturation and clear priority.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, vld_a, clr_a, rst_b, vld_b, clr_b;
  logic [31:0] dat_a, dat_b;
  logic        lck_a, mt_a, mm_a, lck_b, mt_b, mm_b;
  logic [15:0] err_a;
  logic [1:0]  err_b;
  logic [31:0] exp_a, exp_b;

  int ncmp = 0;
  int nfail = 0;

  lfsr_checker u_a (
    .clk(clk), .rst(rst_a), .in_valid(vld_a), .in_data(dat_a), .clear_cnt(clr_a),
    .locked(lck_a), .match(mt_a), .mismatch(mm_a), .err_count(err_a), .expected(exp_a)
  );

  lfsr_checker #(.LOSS_THRESH(255), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst_b), .in_valid(vld_b), .in_data(dat_b), .clear_cnt(clr_b),
    .locked(lck_b), .match(mt_b), .mismatch(mm_b), .err_count(err_b), .expected(exp_b)
  );

  // Observed vectors: {locked, match, mismatch, err_count, expected}
  logic [50:0] obs_a, want_a;
  logic [36:0] obs_b, want_b;
  assign obs_a = {lck_a, mt_a, mm_a, err_a, exp_a};
  assign obs_b = {lck_b, mt_b, mm_b, err_b, exp_b};

  // Drive one cycle of stimulus, then sample 1 ns after the edge.
  task automatic apply_a(input logic r, input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    rst_a = r; vld_a = v; dat_a = d; clr_a = c;
    @(posedge clk); #1;
  endtask

  task automatic apply_b(input logic r, input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    rst_b = r; vld_b = v; dat_b = d; clr_b = c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    apply_a(1, 0, 32'h0, 0);
    want_a = {3'b000, 16'd0, 32'h0}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL reset got %h want %h", obs_a, want_a); nfail++; end
  endtask

  task automatic test_lock_sequence;
    logic [31:0] din [4]  = '{32'h1, 32'h3, 32'h6, 32'hD};
    logic [31:0] pred [4] = '{32'h3, 32'h6, 32'hD, 32'h1B};
    for (int i = 0; i < 4; i++) begin
      apply_a(0, 1, din[i], 0);
      want_a = {1'b1, (i != 0), 1'b0, 16'd0, pred[i]}; ncmp++;
      if (obs_a !== want_a) begin $display("FAIL lock_seq[%0d] got %h want %h", i, obs_a, want_a); nfail++; end
    end
  endtask

  task automatic test_zero_ignore;
    apply_a(1, 0, 32'h0, 0);
    for (int i = 0; i < 2; i++) begin
      apply_a(0, 1, 32'h0, 0);
      want_a = {3'b000, 16'd0, 32'h0}; ncmp++;
      if (obs_a !== want_a) begin $display("FAIL zero_ign[%0d] got %h want %h", i, obs_a, want_a); nfail++; end
    end
    apply_a(0, 1, 32'h1, 0);
    want_a = {3'b100, 16'd0, 32'h3}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL zero_seed got %h want %h", obs_a, want_a); nfail++; end
  endtask

  task automatic test_mismatch_recover;
    apply_a(0, 1, 32'h3, 0);
    want_a = {3'b110, 16'd0, 32'h6}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL recov_pre got %h want %h", obs_a, want_a); nfail++; end
    apply_a(0, 1, 32'h7, 0);
    want_a = {3'b101, 16'd1, 32'hD}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL recov_bad got %h want %h", obs_a, want_a); nfail++; end
    apply_a(0, 1, 32'hD, 0);
    want_a = {3'b110, 16'd1, 32'h1B}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL recov_good got %h want %h", obs_a, want_a); nfail++; end
  endtask

  task automatic test_loss;
    logic [31:0] pred [4] = '{32'h36, 32'h6D, 32'hDB, 32'h1B6};
    // clear_cnt with no data: count clears, lock and prediction hold
    apply_a(0, 0, 32'h0, 1);
    want_a = {3'b100, 16'd0, 32'h1B}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL clear_idle got %h want %h", obs_a, want_a); nfail++; end
    for (int i = 0; i < 4; i++) begin
      apply_a(0, 1, 32'hFFFF_FFFF, 0);
      want_a = {(i != 3), 2'b01, 16'(i + 1), pred[i]}; ncmp++;
      if (obs_a !== want_a) begin $display("FAIL loss[%0d] got %h want %h", i, obs_a, want_a); nfail++; end
    end
    apply_a(0, 0, 32'h5, 0);
    want_a = {3'b000, 16'd4, 32'h1B6}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL loss_hold got %h want %h", obs_a, want_a); nfail++; end
    apply_a(0, 1, 32'h1B, 0);
    want_a = {3'b100, 16'd4, 32'h36}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL loss_relock got %h want %h", obs_a, want_a); nfail++; end
  endtask

  task automatic test_mid_reset;
    apply_a(1, 1, 32'h36, 0);
    want_a = {3'b000, 16'd0, 32'h0}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL midrst got %h want %h", obs_a, want_a); nfail++; end
    apply_a(0, 1, 32'h6D, 0);
    want_a = {3'b100, 16'd0, 32'hDB}; ncmp++;
    if (obs_a !== want_a) begin $display("FAIL midrst_seed got %h want %h", obs_a, want_a); nfail++; end
    apply_a(0, 0, 32'h0, 0);
  endtask

  task automatic test_saturate_clear;
    logic [31:0] pred [5] = '{32'h6, 32'hD, 32'h1B, 32'h36, 32'h6D};
    logic [1:0]  cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_b(1, 0, 32'h0, 0);
    want_b = {3'b000, 2'd0, 32'h0}; ncmp++;
    if (obs_b !== want_b) begin $display("FAIL sat_reset got %h want %h", obs_b, want_b); nfail++; end
    apply_b(0, 1, 32'h1, 0);
    want_b = {3'b100, 2'd0, 32'h3}; ncmp++;
    if (obs_b !== want_b) begin $display("FAIL sat_seed got %h want %h", obs_b, want_b); nfail++; end
    for (int i = 0; i < 5; i++) begin
      apply_b(0, 1, 32'h0, 0);
      want_b = {3'b101, cnt[i], pred[i]}; ncmp++;
      if (obs_b !== want_b) begin $display("FAIL sat[%0d] got %h want %h", i, obs_b, want_b); nfail++; end
    end
    apply_b(0, 1, 32'h0, 1);
    want_b = {3'b101, 2'd0, 32'hDB}; ncmp++;
    if (obs_b !== want_b) begin $display("FAIL clr_prio got %h want %h", obs_b, want_b); nfail++; end
    apply_b(0, 0, 32'h0, 0);
  endtask

  initial begin
    rst_a = 1; vld_a = 0; dat_a = '0; clr_a = 0;
    rst_b = 1; vld_b = 0; dat_b = '0; clr_b = 0;
    test_reset();
    test_lock_sequence();
    test_zero_ignore();
    test_mismatch_recover();
    test_loss();
    test_mid_reset();
    test_saturate_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
